// File: rtl/key_sched_pkg.sv
// Shared constants, conf codes and FSM encoding for the AES round-key schedule.
// Per-conf Nk / W / Nr lookups live here so the controller stays table-free.
package key_sched_pkg;

    localparam int WORD_W      = 32;
    localparam int STORE_DEPTH = 60;

    localparam logic [1:0] CONF_128 = 2'd0;
    localparam logic [1:0] CONF_192 = 2'd1;
    localparam logic [1:0] CONF_256 = 2'd2;
    localparam logic [1:0] CONF_RSV = 2'd3;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    localparam logic [5:0] W_128 = 6'd44;
    localparam logic [5:0] W_192 = 6'd52;
    localparam logic [5:0] W_256 = 6'd60;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] conf);
        case (conf)
            CONF_128: nk_of = NK_128;
            CONF_192: nk_of = NK_192;
            CONF_256: nk_of = NK_256;
            default:  nk_of = 4'd0;
        endcase
    endfunction

    function automatic logic [5:0] w_of(input logic [1:0] conf);
        case (conf)
            CONF_128: w_of = W_128;
            CONF_192: w_of = W_192;
            CONF_256: w_of = W_256;
            default:  w_of = 6'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] conf);
        case (conf)
            CONF_128: nr_of = NR_128;
            CONF_192: nr_of = NR_192;
            CONF_256: nr_of = NR_256;
            default:  nr_of = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/key_word_store.sv
// Round-key word store: 60x32 array, one write port, one registered read
// port returning four consecutive words from a word-aligned base.
module key_word_store
    import key_sched_pkg::*;
(
    input  logic          clk_in,
    input  logic          we_in,
    input  logic [5:0]    wa_in,
    input  logic [31:0]   wd_in,
    input  logic          re_in,
    input  logic [5:0]    ra_in,
    output logic [127:0]  rd_out
);

    logic [WORD_W-1:0] r_mem [STORE_DEPTH];
    logic [127:0]      r_rd;

    // Contents are deliberately not reset; validity is tracked by the controller.
    always_ff @(posedge clk_in) begin
        if (we_in) begin
            r_mem[wa_in] <= wd_in;
        end
        if (re_in) begin
            r_rd <= {r_mem[ra_in],
                     r_mem[ra_in + 6'd1],
                     r_mem[ra_in + 6'd2],
                     r_mem[ra_in + 6'd3]};
        end
    end

    assign rd_out = r_rd;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES round-key schedule controller: sequences the word-serial expander,
// captures the schedule and serves round keys. Option: KEY_SCHED_DEC_EN.
module key_sched_ctrl
    import key_sched_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          load_in,
    input  logic [1:0]    conf_in,
    input  logic [255:0]  key_in,
    output logic          busy_out,
    output logic          ready_out,
    output logic          err_out,
    output logic          xpa_en_out,
    output logic          xpa_start_out,
    output logic [1:0]    xpa_conf_out,
    output logic [31:0]   xpa_key_out,
    input  logic [31:0]   xpa_key_in,
    input  logic          xpa_valid_in,
    input  logic          xpa_last_in,
    input  logic          rd_en_in,
`ifdef KEY_SCHED_DEC_EN
    input  logic          rd_dec_in,
`endif
    input  logic [3:0]    rd_round_in,
    output logic [127:0]  rd_key_out,
    output logic          rd_valid_out
);

    state_t         r_state;
    logic [255:0]   r_key;
    logic [1:0]     r_conf;
    logic [3:0]     r_nk;
    logic [5:0]     r_w;
    logic [3:0]     r_nr;
    logic [5:0]     r_wr_cnt;
    logic           r_busy;
    logic           r_ready;
    logic           r_err;
    logic           r_xpa_en;
    logic           r_xpa_start;
    logic           r_rd_valid;

    logic           w_idle_rdy;
    logic           w_load_ok;
    logic           w_load_bad;
    logic           w_wr;
    logic           w_at_last;
    logic           w_xpa_ok;
    logic           w_xpa_err;
    logic           w_rd_ok;
    logic           w_rd_err;
    logic [3:0]     w_rd_idx;
    logic [31:0]    w_key_word;
    logic [127:0]   w_store_rd;

    assign w_idle_rdy = (r_state == IDLE) || (r_state == READY);
    assign w_load_ok  = w_idle_rdy && load_in && (conf_in != CONF_RSV);
    assign w_load_bad = w_idle_rdy && load_in && (conf_in == CONF_RSV);

    assign w_wr      = (r_state == EXPAND) && xpa_valid_in;
    assign w_at_last = (r_wr_cnt == r_w - 6'd1);
    assign w_xpa_ok  = w_wr && xpa_last_in && w_at_last;
    // Covers both an early last flag and running off the end without one.
    assign w_xpa_err = w_wr && (xpa_last_in != w_at_last);

    assign w_rd_ok  = rd_en_in && (r_state == READY) && (rd_round_in <= r_nr);
    assign w_rd_err = rd_en_in && !w_rd_ok;

`ifdef KEY_SCHED_DEC_EN
    assign w_rd_idx = rd_dec_in ? (r_nr - rd_round_in) : rd_round_in;
`else
    assign w_rd_idx = rd_round_in;
`endif

    always_comb begin
        w_key_word = '0;
        case (r_wr_cnt[2:0])
            3'd0: w_key_word = r_key[255:224];
            3'd1: w_key_word = r_key[223:192];
            3'd2: w_key_word = r_key[191:160];
            3'd3: w_key_word = r_key[159:128];
            3'd4: w_key_word = r_key[127:96];
            3'd5: w_key_word = r_key[95:64];
            3'd6: w_key_word = r_key[63:32];
            3'd7: w_key_word = r_key[31:0];
            default: w_key_word = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_conf      <= '0;
            r_nk        <= '0;
            r_w         <= '0;
            r_nr        <= '0;
            r_wr_cnt    <= '0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_xpa_en    <= 1'b0;
            r_xpa_start <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_err       <= w_load_bad | w_xpa_err | w_rd_err;
            r_rd_valid  <= w_rd_ok;
            r_xpa_start <= 1'b0;
            unique case (r_state)
                IDLE, READY: begin
                    if (w_load_ok) begin
                        r_state     <= EXPAND;
                        r_key       <= key_in;
                        r_conf      <= conf_in;
                        r_nk        <= nk_of(conf_in);
                        r_w         <= w_of(conf_in);
                        r_nr        <= nr_of(conf_in);
                        r_wr_cnt    <= '0;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b0;
                        r_xpa_en    <= 1'b1;
                        r_xpa_start <= 1'b1;
                    end
                end
                EXPAND: begin
                    if (w_wr) begin
                        r_wr_cnt <= r_wr_cnt + 6'd1;
                    end
                    if (w_xpa_ok) begin
                        r_state  <= READY;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_xpa_en <= 1'b0;
                    end else if (w_xpa_err) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_xpa_en <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    key_word_store u_store (
        .clk_in (clk_in),
        .we_in  (w_wr),
        .wa_in  (r_wr_cnt),
        .wd_in  (xpa_key_in),
        .re_in  (w_rd_ok),
        .ra_in  ({w_rd_idx, 2'b00}),
        .rd_out (w_store_rd)
    );

    assign busy_out      = r_busy;
    assign ready_out     = r_ready;
    assign err_out       = r_err;
    assign xpa_en_out    = r_xpa_en;
    assign xpa_start_out = r_xpa_start;
    assign xpa_conf_out  = r_conf;
    assign xpa_key_out   = (r_state == EXPAND && r_wr_cnt < {2'b00, r_nk})
                           ? w_key_word : '0;
    assign rd_valid_out  = r_rd_valid;
    assign rd_key_out    = r_rd_valid ? w_store_rd : '0;

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Round-key schedule controller for the AES core. It takes a cipher key and key-size code from the host and sequences the word-serial key expander through one full expansion. It captures every expanded 32-bit word into a local round-key store and then serves 128-bit round keys to the cipher round datapath by round number. It sits between the host/config interface, the key expander and the encrypt/decrypt round engines.

## Interface
- Parameters: none; all sizes come from `key_sched_pkg`.
- `clk_in` input 1: the single clock. All logic is rising-edge.
- `rst_in` input 1: reset. Synchronous and active-low.
- `load_in` input 1: start a new schedule. Sampled only in IDLE or READY.
- `conf_in` input 2: key size code. 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- `key_in` input 256: cipher key. Word 0 = `[255:224]`. Unused low words are ignored.
- `busy_out` output 1: high in EXPAND.
- `ready_out` output 1: high in READY, meaning the store is valid.
- `err_out` output 1: one-cycle pulse on a rejected load, an expander protocol error or a bad read.
- `xpa_en_out`, `xpa_start_out` output 1 each: expander enable and start.
- `xpa_conf_out` output 2: latched `conf_in`.
- `xpa_key_out` output 32: key word fed to the expander.
- `xpa_key_in` input 32: expanded word from the expander.
- `xpa_valid_in`, `xpa_last_in` input 1 each: expander word-valid and final-word flags.
- `rd_en_in` input 1: round-key read request.
- `rd_round_in` input 4: round index r.
- `rd_key_out` output 128: round key. Words are ordered {w[4r], w[4r+1], w[4r+2], w[4r+3]}, MSB first.
- `rd_valid_out` output 1: read data valid.

## Operation
- States: IDLE, EXPAND, READY.
- Latched on load: the key register (256 bits), the conf register, Nk (4/6/8), total word count W (44/52/60) and round count Nr (10/12/14).
- IDLE/READY with `load_in`=1 and `conf_in`<3:
  - latch key and conf;
  - clear `wr_cnt`;
  - drop `ready_out`;
  - go to EXPAND.
- IDLE/READY with `load_in`=1 and `conf_in`=3: pulse `err_out` and stay in the current state. A valid store remains valid.
- EXPAND:
  - `xpa_en_out`=1 throughout.
  - `xpa_start_out`=1 only in the first EXPAND cycle.
  - `xpa_key_out` = key word[`wr_cnt`] while `wr_cnt`<Nk, else 0.
  - Each cycle with `xpa_valid_in`=1 writes `xpa_key_in` to store[`wr_cnt`] and increments `wr_cnt` (6 bits).
- EXPAND exits:
  - Normal: `xpa_last_in`=1 on the cycle that writes `wr_cnt`=W-1. Go to READY.
  - Early `xpa_last_in` (at `wr_cnt`≠W-1): pulse `err_out` and go to IDLE.
  - `wr_cnt` reaching W without `xpa_last_in`: pulse `err_out` and go to IDLE.
- `load_in` during EXPAND is ignored. It does not queue.
- Reads:
  - Accepted in any state.
  - Valid only in READY with r ≤ Nr: one cycle later `rd_valid_out`=1 with the key.
  - Otherwise one cycle later `rd_valid_out`=0, `rd_key_out`=0 and `err_out` pulses.
- Store index arithmetic is 6 bits: 4r+k with r ≤ 14 never exceeds 59.

## Timing
- Reset (`rst_in`=0 at a clock edge):
  - state goes to IDLE;
  - all outputs go to 0, including the `xpa_*` outputs and `rd_key_out`;
  - `wr_cnt` and the conf register are cleared;
  - the store array is not reset.
- Reset mid-EXPAND aborts the schedule. `ready_out` stays 0 until a later load completes.
- Load accepted at edge 0; first EXPAND cycle is cycle 1, and word 0 is written at edge 1.
- With a compliant expander (one word per cycle), word W-1 is written at edge W. `ready_out` is high from cycle W+1: cycle 45, 53 or 61.
- Read latency is 1 cycle and fully pipelined: one read per cycle.
- Same cycle in READY: a read alongside an accepted load is served from the old store. `ready_out` drops the next cycle.
- Same cycle: a read error and an expander error produce a single `err_out` pulse.

## Configuration
- `KEY_SCHED_DEC_EN` defined:
  - adds port `rd_dec_in` (input, 1 bit);
  - when `rd_dec_in`=1, round r reads the store at round Nr-r, giving decrypt order;
  - the range check is still r ≤ Nr.
- `KEY_SCHED_DEC_EN` undefined: the port is absent and addressing is forward only.

## Structure
- `key_sched_pkg` holds:
  - conf codes `CONF_128`/`CONF_192`/`CONF_256`;
  - per-conf constants Nk, W and Nr, with lookup functions;
  - state encoding `IDLE`/`EXPAND`/`READY`;
  - `WORD_W`=32 and `STORE_DEPTH`=60.
- Sub-module `key_word_store`:
  - 60×32 register array;
  - one write port;
  - one registered read port that returns 4 consecutive words from base 4r.
- All FSM, counter and checking logic stays in `key_sched_ctrl`.

## Test plan
- **AES-128.** Load key 2b7e1516 28aed2a6 abf71588 09cf4f3c with the expander attached.
  - `ready_out` rises at cycle 45.
  - Round 0 reads the key back.
  - Round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- **AES-192.** FIPS-197 A.2 key.
  - Ready at cycle 53.
  - Round 12 = e98ba06f 448c773c 8ecc7204 01002202.
  - Round 13 read → `err_out` pulse and `rd_valid_out`=0.
- **AES-256.** FIPS-197 A.3 key.
  - Ready at cycle 61.
  - Round 14 = fe4890d1 e6188d0b 046df344 706c631e.
  - With `KEY_SCHED_DEC_EN` and `rd_dec_in`=1, round 0 returns the same value.
- **Bad conf.** `conf_in`=3 in READY → one `err_out` pulse, state stays READY and old reads still return the correct keys.
- **Expander faults.** Using a stub expander:
  - `xpa_last_in` at word 20 of AES-128 → `err_out` and IDLE;
  - 44 words without `xpa_last_in` → `err_out` and IDLE.
- **Abort and restart.** Reset at cycle 30 of EXPAND → all outputs 0 and `ready_out`=0. A reload then completes normally.
